settings_line_parser: RTL
=========================

# settings_line_parser

Upstream feeder for the settings data handler. Accepts an ASCII byte stream (one settings line per command, e.g. "5 12\n"), parses two decimal integers, and writes them as 32-bit words to the settings buffer RAM (addr 0 = command, addr 1 = value). It then pulses the handler's start and holds off further input until the handler is idle again. Malformed lines are discarded whole and flagged.

## Interface
Parameters: none (buffer address width fixed at 11, word width fixed at 32).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_valid  in  1  byte valid
- rx_data  in  8  ASCII byte
- rx_ready  out  1  parser accepts a byte this cycle; transfer when rx_valid && rx_ready
- buf_wr_en  out  1  buffer RAM write strobe
- buf_wr_addr  out  11  buffer RAM write address (only 0 or 1)
- buf_wr_data  out  32  buffer RAM write data
- handler_start  out  1  one-cycle start pulse to the settings handler
- handler_busy  in  1  settings handler busy
- busy  out  1  high whenever the state is not IDLE
- parse_error  out  1  one-cycle pulse when a line is rejected
- error_flag  out  1  sticky; set with parse_error, cleared in the START cycle of a committed line

## Operation
- Character classes:
  - digit '0'-'9'.
  - separator: space 0x20 or ',' 0x2C.
  - EOL: 0x0A or 0x0D.
  - minus '-' 0x2D.
  - Any other byte is invalid.
- States: IDLE, TOK1, GAP, TOK2, TRAIL, ERR_SKIP, WR_CMD, WR_DATA, START, HOLD, WAIT_H.
- IDLE:
  - separator or EOL: ignored (empty lines are not errors).
  - digit: acc1 = digit, go to TOK1.
  - minus or invalid byte: error.
- TOK1:
  - digit: acc1 = acc1*10 + d.
  - separator: go to GAP.
  - EOL: error (only one token).
  - other byte: error.
- GAP:
  - separator: ignored.
  - digit: acc2 = d, neg = 0, go to TOK2.
  - minus: neg = 1, acc2 = 0, go to TOK2 with the "no digit yet" flag set.
  - EOL or other byte: error.
- TOK2:
  - digit: acc2 = acc2*10 + d, clears the no-digit flag.
  - separator: go to TRAIL.
  - EOL: commit.
  - minus, or separator/EOL while the no-digit flag is set: error.
- TRAIL:
  - separator: ignored.
  - EOL: commit.
  - digit or minus: error (third token).
  - other byte: error.
- Arithmetic:
  - Accumulate in 36 bits; overflow is an error.
  - acc1 overflows if it exceeds 0xFFFF_FFFF.
  - Unsigned acc2 overflows if it exceeds 0xFFFF_FFFF.
  - Negative acc2 overflows if it exceeds 0x8000_0000.
  - Written value = neg ? (~acc2 + 1) truncated to 32 bits : acc2.
  - "-0" writes 0.
- Error: pulse parse_error, set error_flag, go to ERR_SKIP. If the offending byte was itself an EOL, go to IDLE instead. ERR_SKIP consumes bytes until an EOL (inclusive), then goes to IDLE. No RAM write and no start occur for an errored line.
- Commit sequence (rx_ready = 0 throughout):
  - WR_CMD: buf_wr_en = 1, addr 0, data acc1.
  - WR_DATA: buf_wr_en = 1, addr 1, data = signed value.
  - START: handler_start = 1, clear error_flag.
  - HOLD: one cycle, lets handler_busy rise.
  - WAIT_H: stay while handler_busy = 1; go to IDLE when it is 0.
- Semantic range checks (row ≤ 32, etc.) are not done here; they belong to the handler.

## Timing
- Reset values: rx_ready = 1 (IDLE), busy 0, buf_wr_en 0, buf_wr_addr 0, buf_wr_data 0, handler_start 0, parse_error 0, error_flag 0. Accumulators, neg and the no-digit flag are cleared.
- rx_ready = 1 in IDLE, TOK1, GAP, TOK2, TRAIL and ERR_SKIP; 0 otherwise. One byte is consumed per cycle at most.
- EOL accepted at cycle T:
  - buf_wr_en at T+1 (addr 0) and T+2 (addr 1).
  - handler_start at T+3, HOLD at T+4.
  - Earliest IDLE at T+6, when handler_busy is already 0 at T+5.
- buf_wr_* and handler_start are registered outputs. parse_error is asserted the cycle after the offending byte is accepted.
- rx_valid with rx_ready = 0: the byte is not consumed. The source must hold it; no data is lost.
- Async reset mid-commit aborts immediately with no partial start. A word already written to RAM is left in place.

## Test plan
- Stream "1 20\n" with handler_busy modelled as high for 7 cycles after start:
  - writes (0, 1) then (1, 20).
  - one handler_start pulse; rx_ready low until busy falls.
- "3 -7\r" -> writes (0, 3), (1, 0xFFFF_FFF9).
- Overflow cases:
  - "4 4294967296\n" -> parse_error, no buf_wr_en.
  - "3 -2147483648\n" -> data 0x8000_0000.
- Malformed lines:
  - "5\n", "5 6 7\n", "x 1\n" and "5 -\n" each produce exactly one parse_error pulse and no writes.
  - A following "5 10\n" commits correctly and clears error_flag.
- Separators and empty lines: "\n\n  2,,  9 \n" -> empty lines ignored; writes (0, 2), (1, 9).
- Assert rst_n low during WR_DATA -> all outputs return to reset values; no handler_start. The next valid line parses normally.

Source files
------------

// File: rtl/settings_line_parser.sv
// settings_line_parser
//   Parses one ASCII settings line ("<cmd> <value>\n") into two 32-bit words.
//   It writes them to the settings buffer RAM (addr 0 = command, addr 1 =
//   value), pulses handler_start, and then holds off input until the handler
//   is idle again. A malformed line is dropped whole and flagged.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rx_valid/rx_data    byte stream in; a byte transfers when rx_valid && rx_ready
//   rx_ready            parser can take a byte this cycle
//   buf_wr_en/addr/data registered buffer RAM write port
//   handler_start       registered one-cycle start pulse to the settings handler
//   handler_busy        settings handler busy
//   busy                parser not idle
//   parse_error         one-cycle pulse per rejected line
//   error_flag          sticky error, cleared when a line is committed
module settings_line_parser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        buf_wr_en,
  output logic [10:0] buf_wr_addr,
  output logic [31:0] buf_wr_data,
  output logic        handler_start,
  input  logic        handler_busy,
  output logic        busy,
  output logic        parse_error,
  output logic        error_flag
);

  typedef enum logic [3:0] {
    IDLE, TOK1, GAP, TOK2, TRAIL, ERR_SKIP, WR_CMD, WR_DATA, START, HOLD, WAIT_H
  } state_t;

  localparam logic [35:0] MAX_U = 36'h0_FFFF_FFFF;
  localparam logic [35:0] MAX_N = 36'h0_8000_0000;

  state_t      state, state_next;
  logic [31:0] acc1, acc1_next, acc2, acc2_next;
  logic        neg, neg_next, nodig, nodig_next;
  logic        err;

  logic        accept, is_digit, is_sep, is_eol, is_minus;
  logic [3:0]  dig;
  logic [35:0] acc1_step, acc2_step, limit2;
  logic [31:0] value;

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_sep   = (rx_data == 8'h20) || (rx_data == 8'h2C);
  assign is_eol   = (rx_data == 8'h0A) || (rx_data == 8'h0D);
  assign is_minus = (rx_data == 8'h2D);
  assign dig      = rx_data[3:0];

  assign rx_ready = (state == IDLE) || (state == TOK1) || (state == GAP) ||
                    (state == TOK2) || (state == TRAIL) || (state == ERR_SKIP);
  assign busy     = (state != IDLE);
  assign accept   = rx_valid && rx_ready;

  // Accumulators never hold more than 0xFFFF_FFFF, so acc*10+9 fits in 36 bits
  // and overflow is caught before anything is stored.
  assign acc1_step = {4'd0, acc1} * 36'd10 + {32'd0, dig};
  assign acc2_step = {4'd0, acc2} * 36'd10 + {32'd0, dig};
  assign limit2    = neg ? MAX_N : MAX_U;
  assign value     = neg ? (~acc2 + 32'd1) : acc2;

  always_comb begin
    state_next = state;
    acc1_next  = acc1;
    acc2_next  = acc2;
    neg_next   = neg;
    nodig_next = nodig;
    err        = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (is_digit) begin
          acc1_next  = {28'd0, dig};
          state_next = TOK1;
        end else if (!(is_sep || is_eol)) begin
          err = 1'b1;
        end
      end
      TOK1: if (accept) begin
        if (is_digit) begin
          if (acc1_step > MAX_U) err = 1'b1;
          else                   acc1_next = acc1_step[31:0];
        end else if (is_sep) begin
          state_next = GAP;
        end else begin
          err = 1'b1;
        end
      end
      GAP: if (accept) begin
        if (is_digit) begin
          acc2_next  = {28'd0, dig};
          neg_next   = 1'b0;
          nodig_next = 1'b0;
          state_next = TOK2;
        end else if (is_minus) begin
          acc2_next  = '0;
          neg_next   = 1'b1;
          nodig_next = 1'b1;
          state_next = TOK2;
        end else if (!is_sep) begin
          err = 1'b1;
        end
      end
      TOK2: if (accept) begin
        if (is_digit) begin
          if (acc2_step > limit2) err = 1'b1;
          else begin
            acc2_next  = acc2_step[31:0];
            nodig_next = 1'b0;
          end
        end else if ((is_sep || is_eol) && !nodig) begin
          state_next = is_eol ? WR_CMD : TRAIL;
        end else begin
          err = 1'b1;
        end
      end
      TRAIL: if (accept) begin
        if (is_eol)       state_next = WR_CMD;
        else if (!is_sep) err = 1'b1;
      end
      ERR_SKIP: if (accept && is_eol) state_next = IDLE;
      WR_CMD:   state_next = WR_DATA;
      WR_DATA:  state_next = START;
      START:    state_next = HOLD;
      HOLD:     state_next = WAIT_H;
      WAIT_H:   if (!handler_busy) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    // An offending EOL already ends the line, so there is nothing to skip.
    if (err) state_next = is_eol ? IDLE : ERR_SKIP;
  end

  // Outputs are registered from the next state so they line up with the
  // state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      acc1          <= '0;
      acc2          <= '0;
      neg           <= 1'b0;
      nodig         <= 1'b0;
      buf_wr_en     <= 1'b0;
      buf_wr_addr   <= '0;
      buf_wr_data   <= '0;
      handler_start <= 1'b0;
      parse_error   <= 1'b0;
      error_flag    <= 1'b0;
    end else begin
      state         <= state_next;
      acc1          <= acc1_next;
      acc2          <= acc2_next;
      neg           <= neg_next;
      nodig         <= nodig_next;
      buf_wr_en     <= (state_next == WR_CMD) || (state_next == WR_DATA);
      buf_wr_addr   <= (state_next == WR_DATA) ? 11'd1 : 11'd0;
      buf_wr_data   <= (state_next == WR_CMD)  ? acc1 :
                       (state_next == WR_DATA) ? value : '0;
      handler_start <= (state_next == START);
      parse_error   <= err;
      if (state_next == START) error_flag <= 1'b0;
      else if (err)            error_flag <= 1'b1;
    end
  end

endmodule
